// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default 100 MHz timing for button_event
package btn_pkg;
   // 2'd3 is unused and recovers to IDLE
   typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2} state_t;
   localparam int LONG_CYCLES_DEF   = 50_000_000;
   localparam int REPEAT_CYCLES_DEF = 10_000_000;
endpackage

// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/short/long/repeat/release pulses
//   clk, rst_n        : clock, asynchronous active-low reset
//   btn               : debounced button level
//   repeat_en         : allow repeat pulses while in LONG
//   press             : pulse on the press edge
//   short_release     : pulse on release before the long threshold
//   long_press        : pulse when the hold reaches LONG_CYCLES
//   repeat_pulse      : pulse every REPEAT_CYCLES in LONG with repeat_en
//   long_release      : pulse on release from LONG
//   held              : level, high in HELD or LONG
module button_event
   import btn_pkg::*;
#(
   parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
   parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
   parameter int CNT_W = $clog2((LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES) + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic repeat_en,
   output logic press,
   output logic short_release,
   output logic long_press,
   output logic repeat_pulse,
   output logic long_release,
   output logic held
);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   state_t state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic btn_q, rise;
   logic press_n, short_n, long_n, repeat_n, long_rel_n, held_n;
   assign rise = btn & ~btn_q;
   // btn_q resets high so a button held through reset must be released before it can press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         count         <= '0;
         btn_q         <= 1'b1;
         press         <= 1'b0;
         short_release <= 1'b0;
         long_press    <= 1'b0;
         repeat_pulse  <= 1'b0;
         long_release  <= 1'b0;
         held          <= 1'b0;
      end else begin
         state         <= state_n;
         count         <= count_n;
         btn_q         <= btn;
         press         <= press_n;
         short_release <= short_n;
         long_press    <= long_n;
         repeat_pulse  <= repeat_n;
         long_release  <= long_rel_n;
         held          <= held_n;
      end
   end
   // release is tested before any terminal count, so it always wins
   always_comb begin
      state_n = state;
      count_n = count;
      case (state)
         IDLE: begin
            state_n = rise ? HELD : IDLE;
            count_n = rise ? CNT_W'(1) : '0;
         end
         HELD: begin
            state_n = !btn ? IDLE : (count == LONG_LAST) ? LONG : HELD;
            count_n = (!btn || count == LONG_LAST) ? '0 : count + 1'b1;
         end
         LONG: begin
            state_n = btn ? LONG : IDLE;
            count_n = (!btn || !repeat_en || count == REP_LAST) ? '0 : count + 1'b1;
         end
         default: begin
            state_n = IDLE;
            count_n = '0;
         end
      endcase
   end
   always_comb begin
      press_n    = (state == IDLE) && rise;
      short_n    = (state == HELD) && !btn;
      long_n     = (state == HELD) && btn && (count == LONG_LAST);
      repeat_n   = (state == LONG) && btn && repeat_en && (count == REP_LAST);
      long_rel_n = (state == LONG) && !btn;
      held_n     = (state_n != IDLE);
   end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: randomized and directed check of button_event against a hold-time model
module tb_button_event;
   localparam int L = 8;
   localparam int R = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b1;
   logic repeat_en = 1'b1;
   logic press, short_release, long_press, repeat_pulse, long_release, held;
   logic [5:0] got_v;
   int total = 0;
   int bad = 0;
   bit m_pressed = 1'b0;
   bit m_long = 1'b0;
   bit m_p = 1'b1;
   int m_t = 0;
   int m_run = 0;

   button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .repeat_en(repeat_en),
      .press(press), .short_release(short_release), .long_press(long_press),
      .repeat_pulse(repeat_pulse), .long_release(long_release), .held(held)
   );

   always #5 clk = ~clk;
   assign got_v = {press, short_release, long_press, repeat_pulse, long_release, held};

   task automatic chk(input string tag, input logic [5:0] g, input logic [5:0] e);
      total++;
      assert (g === e) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b (press,short,long,rep,lrel,held)", tag, g, e);
      end
   endtask

   // model: m_t = edges since the press edge, m_run = consecutive repeat_en samples in long
   task automatic step(input bit b, input bit r, input string tag);
      logic [5:0] e = '0;
      btn = b;
      repeat_en = r;
      if (!m_pressed) begin
         if (b && !m_p) begin
            e[5] = 1'b1; m_pressed = 1'b1; m_t = 0; m_long = 1'b0;
         end
      end else if (!b) begin
         if (m_long) e[1] = 1'b1; else e[4] = 1'b1;
         m_pressed = 1'b0;
      end else begin
         m_t++;
         if (!m_long) begin
            if (m_t == L - 1) begin e[3] = 1'b1; m_long = 1'b1; m_run = 0; end
         end else if (r) begin
            m_run++;
            if (m_run == R) begin e[2] = 1'b1; m_run = 0; end
         end else m_run = 0;
      end
      m_p = b;
      e[0] = m_pressed;
      @(posedge clk);
      @(negedge clk);
      chk(tag, got_v, e);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset", got_v, 6'b0);
      rst_n = 1'b1;
      repeat (20) step(1, 1, "armwait");
      step(0, 1, "arm_low");
      step(1, 1, "arm_press");
      repeat (4) step(1, 1, "short_hold");
      step(0, 1, "short_rel");
      step(0, 1, "gap");
      repeat (8) step(1, 1, "long8");
      step(0, 1, "long8_rel");
      step(0, 1, "gap");
      repeat (30) step(1, 1, "rep_hold");
      step(0, 1, "rep_rel");
      step(0, 1, "gap");
      repeat (13) step(1, 1, "pause_a");
      repeat (2) step(1, 0, "pause_off");
      repeat (10) step(1, 1, "pause_b");
      step(0, 1, "pause_rel");
      step(0, 1, "gap");
      repeat (7) step(1, 1, "thr7");
      step(0, 1, "thr_rel");
      step(1, 1, "repress");
      step(0, 1, "repress_rel");
      step(0, 1, "gap");
      repeat (12) step(1, 1, "rst_hold");
      #2 rst_n = 1'b0;
      #1 chk("rst_async", got_v, 6'b0);
      m_pressed = 1'b0;
      m_p = 1'b1;
      @(negedge clk);
      chk("rst_held", got_v, 6'b0);
      rst_n = 1'b1;
      repeat (3) step(1, 1, "post_rst_armwait");
      step(0, 1, "post_rst_low");
      step(1, 1, "post_rst_press");
      step(0, 1, "post_rst_rel");
      for (int i = 0; i < 60; i++) begin
         int hi = $urandom_range(1, 22);
         int lo = $urandom_range(1, 3);
         for (int j = 0; j < hi; j++) step(1, ($urandom_range(0, 7) != 0), "rand_hi");
         for (int j = 0; j < lo; j++) step(0, $urandom_range(0, 1), "rand_lo");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
